// File: rtl/adc_responder.sv
// adc_responder: responder end of a 3-channel 16-bit byte-serial CCD ADC link.
// Serves held RGB pixels byte-by-byte on DATA as the sampler toggles ADCCLK.
// Ports:
//   clk, reset (sync, active-low)
//   pix_valid/pix_ready, red_in/green_in/blue_in : pixel source handshake
//   clr_err                                       : clears sticky flags
//   CDSCLK1, CDSCLK2, ADCCLK                      : interface pins from sampler
//   DATA, conv_done, underrun, proto_err          : byte output and status
module adc_responder #(
  parameter int          SYNC_STAGES = 1,
  parameter logic [15:0] FILL_WORD   = 16'hDEAD,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] red_in,
  input  logic [15:0] green_in,
  input  logic [15:0] blue_in,
  input  logic        clr_err,
  input  logic        CDSCLK1,
  input  logic        CDSCLK2,
  input  logic        ADCCLK,
  output logic [7:0]  DATA,
  output logic        conv_done,
  output logic        underrun,
  output logic        proto_err
);

  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    READOUT
  } state_e;

  state_e state_q, state_d;

  // {CDSCLK1, CDSCLK2, ADCCLK}
  logic [2:0]  sync_q [SYNC_STAGES];
  logic [1:0]  prev_q;

  logic [47:0] hold_q, hold_d;
  logic        full_q, full_d;
  logic [47:0] shift_q, shift_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        under_q, under_d;
  logic        proto_q, proto_d;

  logic        cds1_lvl;
  logic        cds2_rise, cds2_fall, adc_edge;
  logic        take;
  logic [47:0] load_val;
  logic        under_set, proto_set;

  function automatic logic [7:0] pick(input logic [47:0] w,
                                      input logic [2:0]  k);
    case (k)
      3'd0:    pick = w[47:40];
      3'd1:    pick = w[39:32];
      3'd2:    pick = w[31:24];
      3'd3:    pick = w[23:16];
      3'd4:    pick = w[15:8];
      default: pick = w[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {CDSCLK1, CDSCLK2, ADCCLK};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[LAST][1:0];
    end
  end

  assign cds1_lvl  = sync_q[LAST][2];
  assign cds2_rise = sync_q[LAST][1] & ~prev_q[1];
  assign cds2_fall = ~sync_q[LAST][1] & prev_q[1];
  assign adc_edge  = sync_q[LAST][0] ^ prev_q[0];

  assign take     = pix_valid & ~full_q;
  assign load_val = full_q ? hold_q : {3{FILL_WORD}};

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cds2_rise) state_d = ACQUIRE;
      ACQUIRE: if (cds2_fall) state_d = READOUT;
      READOUT: begin
        if (cds2_rise)                    state_d = ACQUIRE;
        else if (adc_edge && k_q == 3'd5) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath and outputs
  always_comb begin
    hold_d    = hold_q;
    full_d    = full_q;
    shift_d   = shift_q;
    k_d       = k_q;
    data_d    = data_q;
    done_d    = 1'b0;
    under_set = 1'b0;
    proto_set = cds1_lvl;
    if (take) begin
      hold_d = {red_in, green_in, blue_in};
      full_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        k_d = 3'd0;
        if (adc_edge) proto_set = 1'b1;
        if (adc_edge || cds2_rise) data_d = IDLE_BYTE;
      end
      ACQUIRE: begin
        if (cds2_fall) begin
          shift_d = load_val;
          if (full_q) full_d = 1'b0;
          else        under_set = 1'b1;
          // same-cycle ADCCLK edge reads byte 0 from the value being loaded
          if (adc_edge) begin
            data_d = pick(load_val, 3'd0);
            k_d    = 3'd1;
          end else begin
            k_d    = 3'd0;
          end
        end else if (adc_edge) begin
          proto_set = 1'b1;
        end
      end
      READOUT: begin
        if (cds2_rise) begin
          proto_set = 1'b1;
          data_d    = IDLE_BYTE;
          k_d       = 3'd0;
        end else if (adc_edge) begin
          data_d = pick(shift_q, k_q);
          if (k_q == 3'd5) begin
            done_d = 1'b1;
            k_d    = 3'd0;
          end else begin
            k_d    = k_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
    under_d = under_set | (under_q & ~clr_err);
    proto_d = proto_set | (proto_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q  <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      k_q     <= '0;
      data_q  <= IDLE_BYTE;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      k_q     <= k_d;
      data_q  <= data_d;
      done_q  <= done_d;
      under_q <= under_d;
      proto_q <= proto_d;
    end
  end

  assign pix_ready = ~full_q;
  assign DATA      = data_q;
  assign conv_done = done_q;
  assign underrun  = under_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: directed self-checking bench for adc_responder.
// Table of conversions plus hand sequences for errors, abort and reset.
module tb_adc_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] red_in, green_in, blue_in;
  logic        clr_err;
  logic        CDSCLK1, CDSCLK2, ADCCLK;
  logic [7:0]  DATA;
  logic        conv_done, underrun, proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  adc_responder dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .clr_err   (clr_err),
    .CDSCLK1   (CDSCLK1),
    .CDSCLK2   (CDSCLK2),
    .ADCCLK    (ADCCLK),
    .DATA      (DATA),
    .conv_done (conv_done),
    .underrun  (underrun),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] r, g, b;
    logic [47:0] bytes;
    logic        under;
  } vec_t;

  vec_t vecs [4];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
  endtask

  task automatic load_pix(input logic [15:0] r, g, b);
    int t;
    red_in    = r;
    green_in  = g;
    blue_in   = b;
    pix_valid = 1'b1;
    t = 0;
    while (!pix_ready && t < 40) begin
      tick(1);
      t++;
    end
    if (!pix_ready) check("load_timeout", 48'd0, 48'd1);
    tick(1);
    pix_valid = 1'b0;
    check("ready_low_held", 48'(pix_ready), 48'd0);
  endtask

  task automatic toggle_adc();
    ADCCLK = ~ADCCLK;
    tick(2);
  endtask

  task automatic run_conv(input string nm, input logic [47:0] exp);
    CDSCLK2 = 1'b1;
    tick(5);
    CDSCLK2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      toggle_adc();
      check({nm, "_byte"}, 48'(DATA), 48'(exp[47-8*i -: 8]));
      check({nm, "_done"}, 48'(conv_done), (i == 5) ? 48'd1 : 48'd0);
      tick(3);
    end
    check({nm, "_done_pulse"}, 48'(conv_done), 48'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 16'h5678, 16'h9ABC, 48'h123456789ABC, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 48'hDEADDEADDEAD, 1'b1};
    vecs[2] = '{1'b1, 16'hA55A, 16'h0F0F, 16'h8001, 48'hA55A0F0F8001, 1'b0};
    vecs[3] = '{1'b1, 16'h0000, 16'hFFFF, 16'h00FF, 48'h0000FFFF00FF, 1'b0};

    reset     = 1'b0;
    pix_valid = 1'b0;
    red_in    = '0;
    green_in  = '0;
    blue_in   = '0;
    clr_err   = 1'b0;
    CDSCLK1   = 1'b0;
    CDSCLK2   = 1'b0;
    ADCCLK    = 1'b0;
    tick(3);
    check("rst_ready", 48'(pix_ready), 48'd1);
    check("rst_data",  48'(DATA), 48'h00);
    check("rst_done",  48'(conv_done), 48'd0);
    check("rst_under", 48'(underrun), 48'd0);
    check("rst_proto", 48'(proto_err), 48'd0);
    reset = 1'b1;
    tick(3);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) load_pix(vecs[v].r, vecs[v].g, vecs[v].b);
      run_conv($sformatf("vec%0d", v), vecs[v].bytes);
      check("vec_under", 48'(underrun), 48'(vecs[v].under));
      check("vec_proto", 48'(proto_err), 48'd0);
      check("vec_ready", 48'(pix_ready), 48'd1);
      do_clr();
      check("vec_clr", 48'(underrun), 48'd0);
    end

    // back-to-back: second pixel waits behind the first
    load_pix(16'h0001, 16'h0002, 16'h0003);
    red_in    = 16'hFFFF;
    green_in  = 16'hFFFF;
    blue_in   = 16'hFFFF;
    pix_valid = 1'b1;
    tick(2);
    check("b2b_ready_held", 48'(pix_ready), 48'd0);
    run_conv("b2b_a", 48'h000100020003);
    check("b2b_second_held", 48'(pix_ready), 48'd0);
    pix_valid = 1'b0;
    run_conv("b2b_b", 48'hFFFFFFFFFFFF);
    check("b2b_under", 48'(underrun), 48'd0);
    check("b2b_proto", 48'(proto_err), 48'd0);

    // ADCCLK edge in IDLE
    toggle_adc();
    check("idle_adc_proto", 48'(proto_err), 48'd1);
    check("idle_adc_data", 48'(DATA), 48'h00);
    toggle_adc();
    do_clr();
    check("idle_clr", 48'(proto_err), 48'd0);

    // seventh edge after a full conversion
    load_pix(16'h1111, 16'h2222, 16'h3333);
    run_conv("seventh", 48'h111122223333);
    check("seventh_hold", 48'(DATA), 48'h33);
    toggle_adc();
    check("seventh_data", 48'(DATA), 48'h00);
    check("seventh_proto", 48'(proto_err), 48'd1);
    toggle_adc();
    do_clr();

    // CDSCLK1 high; set beats a simultaneous clear
    CDSCLK1 = 1'b1;
    tick(2);
    check("cds1_proto", 48'(proto_err), 48'd1);
    clr_err = 1'b1;
    tick(2);
    check("set_wins", 48'(proto_err), 48'd1);
    clr_err = 1'b0;
    CDSCLK1 = 1'b0;
    tick(3);
    do_clr();
    check("cds1_clr", 48'(proto_err), 48'd0);

    // abort after three bytes
    load_pix(16'h4455, 16'h6677, 16'h8899);
    CDSCLK2 = 1'b1;
    tick(5);
    CDSCLK2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle_adc();
      tick(3);
    end
    check("abort_b2", 48'(DATA), 48'h66);
    CDSCLK2 = 1'b1;
    tick(2);
    check("abort_proto", 48'(proto_err), 48'd1);
    check("abort_data", 48'(DATA), 48'h00);
    load_pix(16'hCAFE, 16'hBEEF, 16'hF00D);
    run_conv("after_abort", 48'hCAFEBEEFF00D);
    check("after_abort_under", 48'(underrun), 48'd0);
    if (ADCCLK) begin
      ADCCLK = 1'b0;
      tick(3);
    end
    do_clr();
    check("abort_clr", 48'(proto_err), 48'd0);

    // reset after the fourth byte
    load_pix(16'h0102, 16'h0304, 16'h0506);
    CDSCLK2 = 1'b1;
    tick(5);
    CDSCLK2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      toggle_adc();
      tick(3);
    end
    check("pre_rst_data", 48'(DATA), 48'h04);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_data", 48'(DATA), 48'h00);
    check("mid_rst_ready", 48'(pix_ready), 48'd1);
    check("mid_rst_under", 48'(underrun), 48'd0);
    check("mid_rst_proto", 48'(proto_err), 48'd0);
    tick(2);
    run_conv("post_rst", 48'hDEADDEADDEAD);
    check("post_rst_under", 48'(underrun), 48'd1);
    check("post_rst_proto", 48'(proto_err), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
